// File: rtl/decrypt_seq_ctrl.sv
// Sequencing controller for the LFSR message decrypter: seed recovery, tap search, payload write-out.
// Latency: done 142 cycles after start when tap 0 matches, plus 2 cycles per byte checked in each failed trial.
// Backpressure: none; memory is assumed single-cycle, and start is ignored while busy.
module decrypt_seq_ctrl #(
    parameter int MSG_LEN  = 64,
    parameter int OUT_BASE = 64,
    parameter int CHK_LEN  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] preamble,
    input  logic [7:0] pre_len,
    output logic [7:0] mem_raddr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_waddr,
    output logic [7:0] mem_wdata,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [2:0] tap_idx
);

    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);
    localparam logic [7:0] CHK_LAST = 8'(CHK_LEN);
    localparam logic [7:0] OUT_B    = 8'(OUT_BASE);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD0,
        S_SEED,
        S_CHK_RD,
        S_CHK_CMP,
        S_DEC_RD,
        S_DEC_WR,
        S_DONE,
        S_FAIL
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] pre_reg, pre_nxt;
    logic [7:0] plen_reg, plen_nxt;
    logic [7:0] idx, idx_nxt;
    logic [2:0] trial, trial_nxt;
    logic [4:0] lfsr, lfsr_nxt;
    logic [4:0] seed, seed_nxt;
    logic [7:0] raddr_nxt;
    logic       wr_en_nxt;
    logic [7:0] waddr_nxt;
    logic [7:0] wdata_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       fail_nxt;
    logic [2:0] tap_nxt;
    logic [7:0] plain;

    // The six legal feedback patterns, searched in index order so the lowest match wins.
    function automatic logic [4:0] tap_of(input logic [2:0] k);
        case (k)
            3'd0:    return 5'h1E;
            3'd1:    return 5'h1D;
            3'd2:    return 5'h1B;
            3'd3:    return 5'h17;
            3'd4:    return 5'h14;
            3'd5:    return 5'h12;
            default: return 5'h1E;
        endcase
    endfunction

    function automatic logic [4:0] lfsr_step(input logic [4:0] l, input logic [4:0] taps);
        return {l[3:0], ^(l & taps)};
    endfunction

    // Byte under the current keystream value; the keystream only touches the low five bits.
    assign plain = mem_rdata ^ {3'b000, lfsr};

    // State, datapath and registered outputs; reset clears everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pre_reg   <= 8'd0;
            plen_reg  <= 8'd0;
            idx       <= 8'd0;
            trial     <= 3'd0;
            lfsr      <= 5'd0;
            seed      <= 5'd0;
            mem_raddr <= 8'd0;
            mem_wr_en <= 1'b0;
            mem_waddr <= 8'd0;
            mem_wdata <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            tap_idx   <= 3'd0;
        end else begin
            state     <= state_nxt;
            pre_reg   <= pre_nxt;
            plen_reg  <= plen_nxt;
            idx       <= idx_nxt;
            trial     <= trial_nxt;
            lfsr      <= lfsr_nxt;
            seed      <= seed_nxt;
            mem_raddr <= raddr_nxt;
            mem_wr_en <= wr_en_nxt;
            mem_waddr <= waddr_nxt;
            mem_wdata <= wdata_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            fail      <= fail_nxt;
            tap_idx   <= tap_nxt;
        end
    end

    // Next-state and output decode. The read address is loaded on entry to each
    // read state so the data is back from memory in the state that consumes it.
    always_comb begin
        state_nxt = state;
        pre_nxt   = pre_reg;
        plen_nxt  = plen_reg;
        idx_nxt   = idx;
        trial_nxt = trial;
        lfsr_nxt  = lfsr;
        seed_nxt  = seed;
        raddr_nxt = mem_raddr;
        wr_en_nxt = 1'b0;
        waddr_nxt = mem_waddr;
        wdata_nxt = mem_wdata;
        busy_nxt  = busy;
        done_nxt  = done;
        fail_nxt  = fail;
        tap_nxt   = tap_idx;

        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_nxt = S_LOAD0;
                    pre_nxt   = preamble;
                    // Clamping keeps every payload index inside the message.
                    if (pre_len < 8'd7) begin
                        plen_nxt = 8'd7;
                    end else if (pre_len > 8'd12) begin
                        plen_nxt = 8'd12;
                    end else begin
                        plen_nxt = pre_len;
                    end
                    raddr_nxt = 8'd0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    fail_nxt  = 1'b0;
                    tap_nxt   = 3'd0;
                end
            end

            S_LOAD0: begin
                state_nxt = S_SEED;
            end

            S_SEED: begin
                // Byte 0 is the pad char XORed with the zero-extended seed, so its top bits must match.
                if (mem_rdata[7:5] != pre_reg[7:5]) begin
                    state_nxt = S_FAIL;
                    fail_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    tap_nxt   = 3'd0;
                end else begin
                    seed_nxt  = mem_rdata[4:0] ^ pre_reg[4:0];
                    lfsr_nxt  = mem_rdata[4:0] ^ pre_reg[4:0];
                    trial_nxt = 3'd0;
                    idx_nxt   = 8'd1;
                    raddr_nxt = 8'd1;
                    state_nxt = S_CHK_RD;
                end
            end

            S_CHK_RD: begin
                lfsr_nxt  = lfsr_step(lfsr, tap_of(trial));
                state_nxt = S_CHK_CMP;
            end

            S_CHK_CMP: begin
                if (plain != pre_reg) begin
                    if (trial == 3'd5) begin
                        state_nxt = S_FAIL;
                        fail_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        tap_nxt   = 3'd0;
                    end else begin
                        trial_nxt = trial + 3'd1;
                        lfsr_nxt  = seed;
                        idx_nxt   = 8'd1;
                        raddr_nxt = 8'd1;
                        state_nxt = S_CHK_RD;
                    end
                end else if (idx == CHK_LAST) begin
                    lfsr_nxt  = seed;
                    idx_nxt   = 8'd0;
                    raddr_nxt = 8'd0;
                    tap_nxt   = trial;
                    state_nxt = S_DEC_RD;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    raddr_nxt = idx + 8'd1;
                    state_nxt = S_CHK_RD;
                end
            end

            S_DEC_RD: begin
                state_nxt = S_DEC_WR;
            end

            S_DEC_WR: begin
                // Pad bytes are consumed to keep the keystream aligned but never written.
                if (idx >= plen_reg) begin
                    wr_en_nxt = 1'b1;
                    waddr_nxt = OUT_B + idx - plen_reg;
                    wdata_nxt = plain;
                end
                lfsr_nxt = lfsr_step(lfsr, tap_of(tap_idx));
                if (idx == LAST_IDX) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    idx_nxt   = idx + 8'd1;
                    raddr_nxt = idx + 8'd1;
                    state_nxt = S_DEC_RD;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/decrypt_seq_ctrl.md
# decrypt_seq_ctrl

Sequencing controller for the LFSR message decrypter. On a start pulse it reads the 64-byte encrypted message from data memory words 0..63 and derives the 5-bit LFSR seed from byte 0 and the preamble. It then identifies which of the six legal tap patterns was used by checking the preamble region. Finally it writes the decrypted payload to memory words 64 upward. It sits between the top-level memory mux, which it drives while `busy` is high, and the testbench/host start/done handshake.

## Interface
Parameters:
- `MSG_LEN`, 64: encrypted bytes at memory base 0.
- `OUT_BASE`, 64: first write address of the decrypted payload.
- `CHK_LEN`, 6: preamble bytes checked per tap trial (indices 1..CHK_LEN).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request; sampled only in IDLE, DONE or FAIL.
- `preamble` in 8: pad character (e.g. 8'h7E); latched on start.
- `pre_len` in 8: pad length; latched on start, clamped to 7..12.
- `mem_raddr` out 8: memory read address; `mem_rdata` is valid the cycle after it.
- `mem_rdata` in 8: memory read data.
- `mem_wr_en` out 1: memory write enable.
- `mem_waddr` out 8: memory write address.
- `mem_wdata` out 8: memory write data.
- `busy` out 1: controller owns memory; the top-level mux selects controller ports.
- `done` out 1: decryption complete; level, held until the next start.
- `fail` out 1: no tap pattern matched, or the byte-0 upper bits mismatched; level.
- `tap_idx` out 3: index 0..5 of the matched pattern; valid while `done`=1.

## Operation
- Tap table (index 0..5): 5'h1E, 1D, 1B, 17, 14, 12.
- LFSR step: next = {lfsr[3:0], ^(lfsr & taps)}, 5 bits.
- Keystream byte = {3'b000, lfsr}.
- Reset values: all outputs 0; state IDLE.

States and transitions:
- IDLE → LOAD0 on `start`. In this transition: latch `preamble`; latch clamped `pre_len` (<7→7, >12→12); set busy=1; clear done and fail.
- LOAD0: mem_raddr=0. → SEED.
- SEED:
  - If rdata[7:5] ≠ preamble[7:5] → FAIL.
  - Otherwise seed = rdata[4:0] ^ preamble[4:0]; t=0; lfsr=seed; i=1. → CHK_RD.
- CHK_RD: mem_raddr=i; lfsr steps once, giving the lfsr[i] value. → CHK_CMP.
- CHK_CMP:
  - rdata ^ keystream ≠ preamble: if t=5 → FAIL; otherwise t++, lfsr=seed, i=1 → CHK_RD.
  - Match with i=CHK_LEN → DEC_RD, with lfsr=seed, i=0, tap_idx=t.
  - Match otherwise: i++ → CHK_RD.
- DEC_RD: mem_raddr=i. → DEC_WR.
- DEC_WR: if i ≥ pre_len, write mem[OUT_BASE+i−pre_len] = rdata ^ keystream(lfsr). Then lfsr steps.
  - If i=MSG_LEN−1 → DONE.
  - Otherwise i++ → DEC_RD.
- DONE: done=1, busy=0. `start` → LOAD0 (same actions as from IDLE).
- FAIL: fail=1, busy=0, tap_idx=0, no memory writes performed. `start` → LOAD0.

Rules:
- The lowest matching tap index wins.
- A seed of 0 is legal: the keystream is all zero and tap 0 matches if the pad is intact.
- Total writes per run: MSG_LEN − pre_len (52..57). Addresses OUT_BASE .. OUT_BASE+MSG_LEN−pre_len−1. Words above that range are untouched.
- Addresses are 8-bit with no wrap; the clamp guarantees in-range indices.
- `start` while busy is ignored.

## Timing
- Let E0 be the edge that samples `start`. busy=1 after E0.
- mem_raddr and mem_wr_en/mem_waddr/mem_wdata are registered. A write occurs on the edge that ends DEC_WR.
- Each tap trial costs 2 cycles per byte checked. A failing trial aborts at the first mismatch.
- Tap 0 matching: done=1 and busy=0 after edge E0+142 (2 + 12 + 128).
- Tap k matching: done after E0+142+Σ(cycles of failed trials).
- Worst-case FAIL: after E0+2+72 = E0+74, when all six trials run 6 bytes.
- rst_n low at any point: asynchronously forces IDLE, mem_wr_en=0, busy/done/fail=0. Partial results in memory are left as written.
- A simultaneous start and rst_n low: reset wins.

## Test plan
- "Hey_Hamm_Look_Im_Picasso", preamble 7E, pre_len 9, pat_sel 2, seed 01 → done; tap_idx=2; mem[64..87] holds the string; mem[88..118] holds 7E; fail=0.
- Same message with pat_sel 0, then with 5 → tap_idx 0 with done at E0+142; tap_idx 5 with done later than tap 0.
- pre_len 3 and pre_len 20 → clamped to 7 and 12. Write counts are 57 and 52; the last write addresses are 120 and 115.
- Encrypted byte 1 corrupted (flip bit 7) → fail=1, done=0, no write ever asserted, busy falls after E0+74 or earlier.
- rst_n pulsed low mid-DEC (e.g. E0+60) → mem_wr_en drops the same cycle; all outputs 0. A new start then completes normally.
- Start pulsed while busy → ignored, same completion time. Start in DONE → done clears next cycle and the run repeats with the same result.
